// File: rtl/gen_count_display_if.sv
// Bus bundle for gen_count_display: binary count in, BCD and 7-segment drive out.
interface gen_count_display_if;
    logic [15:0] generation_cnt_i;
    logic [3:0]  an_o;
    logic [7:0]  ssd_o;
    logic [15:0] bcd_o;
    logic        ovf_o;
    logic        bcd_valid_o;

    modport master (
        output generation_cnt_i,
        input  an_o, ssd_o, bcd_o, ovf_o, bcd_valid_o
    );

    modport slave (
        input  generation_cnt_i,
        output an_o, ssd_o, bcd_o, ovf_o, bcd_valid_o
    );
endinterface

// File: rtl/gen_count_display.sv
// Generation count -> double-dabble BCD -> multiplexed 4-digit 7-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module gen_count_display #(
    parameter int SCAN_DIV = 17
) (
    input  logic               clk,
    input  logic               reset,
    gen_count_display_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

    state_t        r_state;
    logic [15:0]   r_shreg;
    logic [19:0]   r_scratch;
    logic [3:0]    r_shcnt;
    logic [15:0]   r_bcd;
    logic          r_ovf;
    logic          r_valid;

    logic [SCAN_DIV-1:0] r_refresh;
    logic [1:0]    r_idx;
    logic [3:0]    r_an;
    logic [7:0]    r_ssd;

    logic [19:0]   w_adj;
    logic [3:0]    w_nib;
    logic [6:0]    w_seg;
    logic          w_dp;
    logic          w_lz;
    logic          w_blank;

    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < 5; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_shreg   <= '0;
            r_scratch <= '0;
            r_shcnt   <= '0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_shreg   <= bus.generation_cnt_i;
                    r_scratch <= '0;
                    r_shcnt   <= '0;
                    r_state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    {r_scratch, r_shreg} <= {w_adj[18:0], r_shreg, 1'b0};
                    r_shcnt <= r_shcnt + 4'd1;
                    if (r_shcnt == 4'd15)
                        r_state <= S_COMMIT;
                end
                S_COMMIT: begin
                    // Fifth BCD digit nonzero means the count exceeds 9999
                    if (r_scratch[19:16] != 4'd0) begin
                        r_bcd <= 16'h9999;
                        r_ovf <= 1'b1;
                    end else begin
                        r_bcd <= r_scratch[15:0];
                        r_ovf <= 1'b0;
                    end
                    r_valid <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_nib = r_bcd[{r_idx, 2'b00} +: 4];
    assign w_dp  = ~((r_idx == 2'd0) && r_ovf);

    always_comb begin
        case (w_nib)
            4'd0:    w_seg = 7'h40;
            4'd1:    w_seg = 7'h79;
            4'd2:    w_seg = 7'h24;
            4'd3:    w_seg = 7'h30;
            4'd4:    w_seg = 7'h19;
            4'd5:    w_seg = 7'h12;
            4'd6:    w_seg = 7'h02;
            4'd7:    w_seg = 7'h78;
            4'd8:    w_seg = 7'h00;
            4'd9:    w_seg = 7'h10;
            default: w_seg = 7'h7F;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        case (r_idx)
            2'd3:    w_lz = (r_bcd[15:12] == 4'd0);
            2'd2:    w_lz = (r_bcd[15:8] == 8'd0);
            2'd1:    w_lz = (r_bcd[15:4] == 12'd0);
            default: w_lz = 1'b0;
        endcase
    end
`else
    assign w_lz = 1'b0;
`endif

    assign w_blank = w_lz || (w_nib > 4'd9);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_refresh <= '0;
            r_idx     <= 2'd0;
            r_an      <= 4'b1111;
            r_ssd     <= 8'hFF;
        end else begin
            r_refresh <= r_refresh + SCAN_DIV'(1);
            if (&r_refresh)
                r_idx <= r_idx + 2'd1;
            r_an  <= ~(4'b0001 << r_idx);
            r_ssd <= w_blank ? 8'hFF : {w_dp, w_seg};
        end
    end

    assign bus.an_o        = r_an;
    assign bus.ssd_o       = r_ssd;
    assign bus.bcd_o       = r_bcd;
    assign bus.ovf_o       = r_ovf;
    assign bus.bcd_valid_o = r_valid;
endmodule

// File: tb/tb_gen_count_display.sv
// Randomized bench for gen_count_display against a decimal-arithmetic timing model.
module tb_gen_count_display;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    gen_count_display_if bus();

    gen_count_display #(.SCAN_DIV(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [15:0] snap = '0;
    logic [15:0] m_bcd = '0;
    logic [15:0] m_disp = '0;
    logic        m_ovf = 1'b0;
    logic        m_dovf = 1'b0;
    logic        m_valid = 1'b0;

    function automatic logic [16:0] conv(input logic [15:0] n);
        int v;
        logic [3:0] d3, d2, d1, d0;
        v = int'(n);
        if (v > 9999) return {1'b1, 16'h9999};
        d3 = 4'(v / 1000);
        d2 = 4'((v / 100) % 10);
        d1 = 4'((v / 10) % 10);
        d0 = 4'(v % 10);
        return {1'b0, d3, d2, d1, d0};
    endfunction

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: return 8'hC0;
            4'd1: return 8'hF9;
            4'd2: return 8'hA4;
            4'd3: return 8'hB0;
            4'd4: return 8'h99;
            4'd5: return 8'h92;
            4'd6: return 8'h82;
            4'd7: return 8'hF8;
            4'd8: return 8'h80;
            4'd9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Conversion n commits at cycle 18n after reset release, sampled at cycle 18n-17
    always @(posedge clk) begin
        if (reset) begin
            cyc <= 0;
            m_bcd <= '0;
            m_ovf <= 1'b0;
            m_valid <= 1'b0;
            m_disp <= '0;
            m_dovf <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            m_disp <= m_bcd;
            m_dovf <= m_ovf;
            m_valid <= 1'b0;
            if ((cyc + 1) % 18 == 1) snap <= bus.generation_cnt_i;
            if ((cyc + 1) % 18 == 0) begin
                {m_ovf, m_bcd} <= conv(snap);
                m_valid <= 1'b1;
            end
        end
    end

    function automatic logic [3:0] exp_an();
        logic [3:0] one;
        int d;
        if (cyc == 0) return 4'b1111;
        d = ((cyc - 1) >> 2) & 3;
        one = 4'b0001 << d;
        return ~one;
    endfunction

    function automatic logic [7:0] exp_ssd();
        int d;
        logic [7:0] s;
        logic blank;
        if (cyc == 0) return 8'hFF;
        d = ((cyc - 1) >> 2) & 3;
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && (m_disp >> (4 * d)) == 16'd0) blank = 1'b1;
`endif
        if (blank) return 8'hFF;
        s = seg7(m_disp[4*d +: 4]);
        s[7] = !(d == 0 && m_dovf);
        return s;
    endfunction

    task automatic test_reset();
        bus.generation_cnt_i = 16'd1234;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks += 4;
            if (bus.an_o !== 4'b1111) begin errors++; $display("FAIL rst_an got=%b exp=1111", bus.an_o); end
            if (bus.ssd_o !== 8'hFF) begin errors++; $display("FAIL rst_ssd got=%h exp=ff", bus.ssd_o); end
            if (bus.bcd_o !== 16'h0) begin errors++; $display("FAIL rst_bcd got=%h exp=0000", bus.bcd_o); end
            if (bus.bcd_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", bus.bcd_valid_o); end
        end
        reset = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            checks++;
            if (bus.bcd_valid_o !== (i == 18)) begin
                errors++; $display("FAIL rst_first_pulse cyc=%0d got=%b exp=%b", i, bus.bcd_valid_o, (i == 18));
            end
            if (i == 1) begin
                checks++;
                if (bus.an_o !== 4'b1110) begin errors++; $display("FAIL rst_an_cyc1 got=%b exp=1110", bus.an_o); end
            end
        end
        checks += 2;
        if (bus.bcd_o !== 16'h1234) begin errors++; $display("FAIL rst_bcd1234 got=%h exp=1234", bus.bcd_o); end
        if (bus.ovf_o !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b exp=0", bus.ovf_o); end
    endtask

    task automatic test_scan();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            checks += 2;
            if (bus.an_o !== exp_an()) begin errors++; $display("FAIL scan_an cyc=%0d got=%b exp=%b", cyc, bus.an_o, exp_an()); end
            if (bus.ssd_o !== exp_ssd()) begin errors++; $display("FAIL scan_ssd cyc=%0d got=%h exp=%h", cyc, bus.ssd_o, exp_ssd()); end
        end
    endtask

    task automatic test_values(input logic [15:0] v, input int hold);
        bus.generation_cnt_i = v;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks += 5;
            if (bus.bcd_o !== m_bcd) begin errors++; $display("FAIL val_bcd in=%0d cyc=%0d got=%h exp=%h", v, cyc, bus.bcd_o, m_bcd); end
            if (bus.ovf_o !== m_ovf) begin errors++; $display("FAIL val_ovf in=%0d cyc=%0d got=%b exp=%b", v, cyc, bus.ovf_o, m_ovf); end
            if (bus.bcd_valid_o !== m_valid) begin errors++; $display("FAIL val_valid in=%0d cyc=%0d got=%b exp=%b", v, cyc, bus.bcd_valid_o, m_valid); end
            if (bus.an_o !== exp_an()) begin errors++; $display("FAIL val_an in=%0d cyc=%0d got=%b exp=%b", v, cyc, bus.an_o, exp_an()); end
            if (bus.ssd_o !== exp_ssd()) begin errors++; $display("FAIL val_ssd in=%0d cyc=%0d got=%h exp=%h", v, cyc, bus.ssd_o, exp_ssd()); end
        end
    endtask

    task automatic test_boundaries();
        logic [15:0] vals [3];
        bit found;
        vals[0] = 16'd9999; vals[1] = 16'd10000; vals[2] = 16'd65535;
        for (int k = 0; k < 3; k++) begin
            test_values(vals[k], 40);
            checks += 2;
            if (bus.bcd_o !== 16'h9999) begin errors++; $display("FAIL bnd_bcd in=%0d got=%h exp=9999", vals[k], bus.bcd_o); end
            if (bus.ovf_o !== (k != 0)) begin errors++; $display("FAIL bnd_ovf in=%0d got=%b exp=%b", vals[k], bus.ovf_o, (k != 0)); end
            found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                @(negedge clk);
                if (bus.an_o === 4'b1110) found = 1'b1;
            end
            checks++;
            if (!found) begin
                errors++; $display("FAIL bnd_digit0_timeout in=%0d got=%b exp=1110", vals[k], bus.an_o);
            end else if (bus.ssd_o !== ((k != 0) ? 8'h10 : 8'h90)) begin
                errors++; $display("FAIL bnd_dp in=%0d got=%h exp=%h", vals[k], bus.ssd_o, (k != 0) ? 8'h10 : 8'h90);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] v;
        test_values(16'd0, 40);
        test_values(16'd42, 40);
        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 3) == 0) v = 16'($urandom_range(0, 65535));
            else v = 16'($urandom_range(0, 9999));
            test_values(v, int'($urandom_range(1, 40)));
        end
        test_values(16'd7, 40);
    endtask

    task automatic test_mid_change();
        int pulses;
        bus.generation_cnt_i = 16'd5;
        pulses = 0;
        for (int i = 0; i < 60 && pulses < 2; i++) begin
            @(negedge clk);
            if (bus.bcd_valid_o === 1'b1) pulses++;
        end
        checks++;
        if (pulses < 2) begin errors++; $display("FAIL mid_sync_timeout got=%0d exp=2", pulses); end
        for (int k = 1; k <= 5; k++) @(negedge clk);
        bus.generation_cnt_i = 16'd7;
        for (int k = 6; k <= 36; k++) begin
            @(negedge clk);
            checks += 2;
            if (bus.bcd_valid_o !== (k == 18 || k == 36)) begin
                errors++; $display("FAIL mid_valid k=%0d got=%b exp=%b", k, bus.bcd_valid_o, (k == 18 || k == 36));
            end
            if (bus.bcd_o !== ((k == 36) ? 16'h0007 : 16'h0005)) begin
                errors++; $display("FAIL mid_bcd k=%0d got=%h exp=%h", k, bus.bcd_o, (k == 36) ? 16'h0007 : 16'h0005);
            end
        end
    endtask

    task automatic test_mid_reset();
        bit found;
        bus.generation_cnt_i = 16'd321;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus.bcd_valid_o === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL mrst_sync_timeout got=0 exp=1"); end
        for (int k = 1; k <= 10; k++) @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks += 2;
            if (bus.bcd_valid_o !== 1'b0) begin errors++; $display("FAIL mrst_valid got=%b exp=0", bus.bcd_valid_o); end
            if (bus.bcd_o !== 16'h0) begin errors++; $display("FAIL mrst_bcd got=%h exp=0000", bus.bcd_o); end
        end
        bus.generation_cnt_i = 16'd4321;
        reset = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            checks += 2;
            if (bus.bcd_valid_o !== (i == 18)) begin
                errors++; $display("FAIL mrst_pulse i=%0d got=%b exp=%b", i, bus.bcd_valid_o, (i == 18));
            end
            if (bus.bcd_o !== ((i == 18) ? 16'h4321 : 16'h0)) begin
                errors++; $display("FAIL mrst_bcd i=%0d got=%h exp=%h", i, bus.bcd_o, (i == 18) ? 16'h4321 : 16'h0);
            end
        end
        test_values(16'd4321, 20);
    endtask

    initial begin
        bus.generation_cnt_i = 16'd1234;
        test_reset();
        test_scan();
        test_boundaries();
        test_random();
        test_mid_change();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
